regfile_scoreboard: RTL and testbench

Parametrised register file with write-through bypass, per-register pending-write scoreboard, and a privileged write port for protected upper registers. It sits in the decode stage of the pipelined processor. It gives operands to the execute stage, takes writebacks from the last stage, and stalls decode while a source register still has an outstanding write in flight.

---
 rtl/regfile_scoreboard_if.sv | 40 ++++
 rtl/regfile_scoreboard.sv | 120 ++++++++++++
 tb/tb_regfile_scoreboard.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_scoreboard_if.sv
// rtl/regfile_scoreboard_if.sv - operand read, issue, writeback and system-write bundle
interface regfile_scoreboard_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4
);
    logic [ADDR_W-1:0] rd_addr1;
    logic [ADDR_W-1:0] rd_addr2;
    logic              rd_use1;
    logic              rd_use2;
    logic [DATA_W-1:0] rd_data1;
    logic [DATA_W-1:0] rd_data2;
    logic              rd_busy1;
    logic              rd_busy2;
    logic              iss_en;
    logic [ADDR_W-1:0] iss_addr;
    logic              stall;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              sys_wr_en;
    logic [ADDR_W-1:0] sys_wr_addr;
    logic [DATA_W-1:0] sys_wr_data;
    logic              wr_err;

    modport master (
        output rd_addr1, rd_addr2, rd_use1, rd_use2,
        output iss_en, iss_addr,
        output wr_en, wr_addr, wr_data,
        output sys_wr_en, sys_wr_addr, sys_wr_data,
        input  rd_data1, rd_data2, rd_busy1, rd_busy2, stall, wr_err
    );

    modport slave (
        input  rd_addr1, rd_addr2, rd_use1, rd_use2,
        input  iss_en, iss_addr,
        input  wr_en, wr_addr, wr_data,
        input  sys_wr_en, sys_wr_addr, sys_wr_data,
        output rd_data1, rd_data2, rd_busy1, rd_busy2, stall, wr_err
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - register file with bypass, pending-write scoreboard and protected system port
module regfile_scoreboard #(
    parameter int DATA_W    = 32,
    parameter int NUM_REGS  = 16,
    parameter int ADDR_W    = $clog2(NUM_REGS),
    parameter int PROT_BASE = 14,
    parameter int CNT_W     = 2,
    parameter int ZERO_R0   = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    regfile_scoreboard_if.slave   bus
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic [CNT_W-1:0]  cnt_q  [NUM_REGS];
    logic [CNT_W-1:0]  cnt_d  [NUM_REGS];
    logic              wr_err_q;
    logic              wr_err_d;

    logic wr_legal;
    logic accept;
    logic full_hit;

    function automatic logic is_prot(input logic [ADDR_W-1:0] a);
        return int'({1'b0, a}) >= PROT_BASE;
    endfunction

    function automatic logic is_zero(input logic [ADDR_W-1:0] a);
        return (ZERO_R0 != 0) && (a == '0);
    endfunction

    assign wr_legal = bus.wr_en && !is_prot(bus.wr_addr);

    // A legal writeback only retires a pending write if one is outstanding (floor at zero).
    function automatic logic dec_hit(input logic [ADDR_W-1:0] a);
        return wr_legal && (bus.wr_addr == a) && (cnt_q[a] != '0);
    endfunction

    function automatic logic busy_of(input logic [ADDR_W-1:0] a);
        logic [CNT_W-1:0] rem;
        rem = cnt_q[a];
        if (dec_hit(a)) begin
            rem = rem - CNT_W'(1);
        end
        return (rem != '0) && !is_prot(a) && !is_zero(a);
    endfunction

    function automatic logic [DATA_W-1:0] read_of(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        if (is_zero(a)) begin
            v = '0;
        end else if (bus.sys_wr_en && (bus.sys_wr_addr == a)) begin
            v = bus.sys_wr_data;
        end else if (wr_legal && (bus.wr_addr == a)) begin
            v = bus.wr_data;
        end else begin
            v = regs_q[a];
        end
        return v;
    endfunction

    always_comb begin
        bus.rd_data1 = read_of(bus.rd_addr1);
        bus.rd_data2 = read_of(bus.rd_addr2);
        bus.rd_busy1 = busy_of(bus.rd_addr1);
        bus.rd_busy2 = busy_of(bus.rd_addr2);
        full_hit     = bus.iss_en && (cnt_q[bus.iss_addr] == CNT_MAX) && !dec_hit(bus.iss_addr);
        bus.stall    = (bus.rd_use1 && bus.rd_busy1) || (bus.rd_use2 && bus.rd_busy2) || full_hit;
        accept       = bus.iss_en && !bus.stall && !is_prot(bus.iss_addr) && !is_zero(bus.iss_addr);
        bus.wr_err   = wr_err_q;
    end

    // Issue and writeback meeting on one register cancel; otherwise each moves the count by one.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (accept && (bus.iss_addr == ADDR_W'(i))) begin
                if (!(wr_legal && (bus.wr_addr == ADDR_W'(i)))) begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else if (dec_hit(ADDR_W'(i))) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    // The system port overrides a same-cycle writeback to the same register.
    always_comb begin
        for (int i = 0; i < NUM_REGS; i++) begin
            regs_d[i] = regs_q[i];
            if (!is_zero(ADDR_W'(i))) begin
                if (bus.sys_wr_en && (bus.sys_wr_addr == ADDR_W'(i))) begin
                    regs_d[i] = bus.sys_wr_data;
                end else if (wr_legal && (bus.wr_addr == ADDR_W'(i))) begin
                    regs_d[i] = bus.wr_data;
                end
            end
        end
        wr_err_d = bus.wr_en && is_prot(bus.wr_addr);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
                cnt_q[i]  <= '0;
            end
            wr_err_q <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= regs_d[i];
                cnt_q[i]  <= cnt_d[i];
            end
            wr_err_q <= wr_err_d;
        end
    end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb/tb_regfile_scoreboard.sv - randomized and directed checks of regfile_scoreboard against a behavioural model
module tb_regfile_scoreboard;
    localparam int DW   = 32;
    localparam int NR   = 16;
    localparam int AW   = 4;
    localparam int PB   = 14;
    localparam int CMAX = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [AW-1:0] s_rd_addr1, s_rd_addr2, s_iss_addr, s_wr_addr, s_sys_wr_addr;
    logic          s_rd_use1, s_rd_use2, s_iss_en, s_wr_en, s_sys_wr_en;
    logic [DW-1:0] s_wr_data, s_sys_wr_data;

    regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) bus0 ();
    regfile_scoreboard_if #(.DATA_W(DW), .ADDR_W(AW)) bus1 ();

    assign bus0.rd_addr1 = s_rd_addr1;       assign bus1.rd_addr1 = s_rd_addr1;
    assign bus0.rd_addr2 = s_rd_addr2;       assign bus1.rd_addr2 = s_rd_addr2;
    assign bus0.rd_use1 = s_rd_use1;         assign bus1.rd_use1 = s_rd_use1;
    assign bus0.rd_use2 = s_rd_use2;         assign bus1.rd_use2 = s_rd_use2;
    assign bus0.iss_en = s_iss_en;           assign bus1.iss_en = s_iss_en;
    assign bus0.iss_addr = s_iss_addr;       assign bus1.iss_addr = s_iss_addr;
    assign bus0.wr_en = s_wr_en;             assign bus1.wr_en = s_wr_en;
    assign bus0.wr_addr = s_wr_addr;         assign bus1.wr_addr = s_wr_addr;
    assign bus0.wr_data = s_wr_data;         assign bus1.wr_data = s_wr_data;
    assign bus0.sys_wr_en = s_sys_wr_en;     assign bus1.sys_wr_en = s_sys_wr_en;
    assign bus0.sys_wr_addr = s_sys_wr_addr; assign bus1.sys_wr_addr = s_sys_wr_addr;
    assign bus0.sys_wr_data = s_sys_wr_data; assign bus1.sys_wr_data = s_sys_wr_data;

    regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .PROT_BASE(PB), .CNT_W(2), .ZERO_R0(0))
        u_dut0 (.clk(clk), .reset(reset), .bus(bus0.slave));
    regfile_scoreboard #(.DATA_W(DW), .NUM_REGS(NR), .ADDR_W(AW), .PROT_BASE(PB), .CNT_W(2), .ZERO_R0(1))
        u_dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    int checks = 0;
    int failures = 0;

    // Model: index 0 is the plain file, index 1 has R0 hardwired to zero.
    int            m_cnt [2][NR];
    logic [DW-1:0] m_reg [2][NR];
    bit            m_err [2];

    function automatic bit prot(input int a);
        return a >= PB;
    endfunction

    function automatic bit zr(input int k, input int a);
        return (k == 1) && (a == 0);
    endfunction

    function automatic bit wlegal();
        return s_wr_en && !prot(int'(s_wr_addr));
    endfunction

    function automatic logic [DW-1:0] exp_data(input int k, input int a);
        if (zr(k, a)) return '0;
        if (s_sys_wr_en && int'(s_sys_wr_addr) == a) return s_sys_wr_data;
        if (wlegal() && int'(s_wr_addr) == a) return s_wr_data;
        return m_reg[k][a];
    endfunction

    function automatic int pending_after(input int k, input int a);
        int c;
        c = m_cnt[k][a];
        if (wlegal() && int'(s_wr_addr) == a && c > 0) c = c - 1;
        return c;
    endfunction

    function automatic bit exp_busy(input int k, input int a);
        return !prot(a) && !zr(k, a) && pending_after(k, a) != 0;
    endfunction

    function automatic bit exp_stall(input int k);
        return (s_rd_use1 && exp_busy(k, int'(s_rd_addr1))) ||
               (s_rd_use2 && exp_busy(k, int'(s_rd_addr2))) ||
               (s_iss_en && pending_after(k, int'(s_iss_addr)) == CMAX);
    endfunction

    task automatic m_clear();
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < NR; i++) begin
                m_cnt[k][i] = 0;
                m_reg[k][i] = '0;
            end
            m_err[k] = 1'b0;
        end
    endtask

    task automatic m_step();
        int wa, ia, sa;
        bit wl, acc;
        wa = int'(s_wr_addr);
        ia = int'(s_iss_addr);
        sa = int'(s_sys_wr_addr);
        wl = wlegal();
        for (int k = 0; k < 2; k++) begin
            acc = s_iss_en && !exp_stall(k) && !prot(ia) && !zr(k, ia);
            if (!(acc && wl && wa == ia)) begin
                if (acc) m_cnt[k][ia] = m_cnt[k][ia] + 1;
                if (wl && m_cnt[k][wa] > 0) m_cnt[k][wa] = m_cnt[k][wa] - 1;
            end
            if (wl && !zr(k, wa)) m_reg[k][wa] = s_wr_data;
            if (s_sys_wr_en && !zr(k, sa)) m_reg[k][sa] = s_sys_wr_data;
            m_err[k] = s_wr_en && prot(wa);
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) m_clear();
        else m_step();
    end

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    task automatic cmp(input int k, input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                       input logic b1, input logic b2, input logic st, input logic er);
        chk($sformatf("dut%0d rd_data1", k), d1, exp_data(k, int'(s_rd_addr1)));
        chk($sformatf("dut%0d rd_data2", k), d2, exp_data(k, int'(s_rd_addr2)));
        chk($sformatf("dut%0d rd_busy1", k), DW'(b1), DW'(exp_busy(k, int'(s_rd_addr1))));
        chk($sformatf("dut%0d rd_busy2", k), DW'(b2), DW'(exp_busy(k, int'(s_rd_addr2))));
        chk($sformatf("dut%0d stall", k), DW'(st), DW'(exp_stall(k)));
        chk($sformatf("dut%0d wr_err", k), DW'(er), DW'(m_err[k]));
    endtask

    always @(negedge clk) begin
        cmp(0, bus0.rd_data1, bus0.rd_data2, bus0.rd_busy1, bus0.rd_busy2, bus0.stall, bus0.wr_err);
        cmp(1, bus1.rd_data1, bus1.rd_data2, bus1.rd_busy1, bus1.rd_busy2, bus1.stall, bus1.wr_err);
    end

    task automatic idle();
        s_rd_addr1 = '0; s_rd_addr2 = '0; s_rd_use1 = 1'b0; s_rd_use2 = 1'b0;
        s_iss_en = 1'b0; s_iss_addr = '0;
        s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0;
        s_sys_wr_en = 1'b0; s_sys_wr_addr = '0; s_sys_wr_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] raddr();
        return ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 3)) : AW'($urandom_range(0, NR - 1));
    endfunction

    initial begin
        m_clear();
        idle();
        reset = 1'b0;
        repeat (3) tick();
        for (int a = 0; a < NR; a++) begin
            s_rd_addr1 = AW'(a);
            s_rd_addr2 = AW'(NR - 1 - a);
            #1;
            chk("reset rd_data1", bus0.rd_data1, 32'h0);
            chk("reset rd_busy1", DW'(bus0.rd_busy1), 32'h0);
            chk("reset stall", DW'(bus0.stall), 32'h0);
        end
        idle();
        tick();
        reset = 1'b1;
        tick();

        // Read-after-issue hazard resolved by a same-cycle writeback.
        s_iss_en = 1'b1; s_iss_addr = 4'd5;
        tick();
        idle();
        s_rd_addr1 = 4'd5; s_rd_use1 = 1'b1;
        #1 chk("hazard stall", DW'(bus0.stall), 32'h1);
        s_wr_en = 1'b1; s_wr_addr = 4'd5; s_wr_data = 32'hDEADBEEF;
        #1 chk("bypass stall", DW'(bus0.stall), 32'h0);
        chk("bypass data", bus0.rd_data1, 32'hDEADBEEF);
        tick();
        idle();

        // Saturating pending counter on R7.
        s_iss_en = 1'b1; s_iss_addr = 4'd7;
        repeat (3) tick();
        #1 chk("full stall", DW'(bus0.stall), 32'h1);
        tick();
        idle();
        s_rd_addr1 = 4'd7;
        for (int n = 0; n < 3; n++) begin
            s_wr_en = 1'b1; s_wr_addr = 4'd7; s_wr_data = 32'h700 + DW'(n);
            tick();
            s_wr_en = 1'b0;
            #1 chk("r7 busy after wb", DW'(bus0.rd_busy1), (n < 2) ? 32'h1 : 32'h0);
        end
        idle();

        // Protected register: writeback refused, system port accepted.
        s_wr_en = 1'b1; s_wr_addr = 4'd14; s_wr_data = 32'h1234;
        tick();
        idle();
        s_rd_addr1 = 4'd14;
        #1 chk("prot wr_err", DW'(bus0.wr_err), 32'h1);
        chk("prot unchanged", bus0.rd_data1, 32'h0);
        s_sys_wr_en = 1'b1; s_sys_wr_addr = 4'd14; s_sys_wr_data = 32'h1234;
        tick();
        s_sys_wr_en = 1'b0;
        #1 chk("sys r14 data", bus0.rd_data1, 32'h1234);
        chk("sys wr_err low", DW'(bus0.wr_err), 32'h0);
        s_wr_en = 1'b1; s_wr_addr = 4'd15;
        tick();
        tick();
        #1 chk("b2b wr_err", DW'(bus0.wr_err), 32'h1);
        idle();

        // System port wins a same-address collision; writeback still retires the count.
        s_iss_en = 1'b1; s_iss_addr = 4'd2;
        tick();
        idle();
        s_rd_addr1 = 4'd2;
        s_sys_wr_en = 1'b1; s_sys_wr_addr = 4'd2; s_sys_wr_data = 32'hAAAA;
        s_wr_en = 1'b1; s_wr_addr = 4'd2; s_wr_data = 32'h5555;
        #1 chk("collide comb", bus0.rd_data1, 32'hAAAA);
        chk("collide busy", DW'(bus0.rd_busy1), 32'h0);
        tick();
        idle();
        s_rd_addr1 = 4'd2;
        #1 chk("collide stored", bus0.rd_data1, 32'hAAAA);
        chk("collide cnt", DW'(bus0.rd_busy1), 32'h0);

        // Hardwired R0 on the second instance.
        s_rd_addr1 = 4'd0; s_rd_use1 = 1'b1;
        s_wr_en = 1'b1; s_wr_addr = 4'd0; s_wr_data = 32'hFFFF;
        s_iss_en = 1'b1; s_iss_addr = 4'd0;
        #1 chk("r0 data", bus1.rd_data1, 32'h0);
        chk("r0 stall", DW'(bus1.stall), 32'h0);
        tick();
        idle();
        s_rd_addr1 = 4'd0; s_rd_use1 = 1'b1;
        #1 chk("r0 after data", bus1.rd_data1, 32'h0);
        chk("r0 after busy", DW'(bus1.rd_busy1), 32'h0);
        chk("plain r0 written", bus0.rd_data1, 32'hFFFF);
        idle();

        // Asynchronous reset with two writes pending on R3.
        s_wr_en = 1'b1; s_wr_addr = 4'd3; s_wr_data = 32'h33;
        tick();
        idle();
        s_iss_en = 1'b1; s_iss_addr = 4'd3;
        tick();
        tick();
        idle();
        s_rd_addr1 = 4'd3;
        #1 chk("r3 busy pre", DW'(bus0.rd_busy1), 32'h1);
        chk("r3 data pre", bus0.rd_data1, 32'h33);
        reset = 1'b0;
        #1 chk("r3 busy reset", DW'(bus0.rd_busy1), 32'h0);
        chk("r3 data reset", bus0.rd_data1, 32'h0);
        @(posedge clk);
        #3 reset = 1'b1;
        tick();

        for (int c = 0; c < 3000; c++) begin
            s_rd_addr1 = raddr();
            s_rd_addr2 = raddr();
            s_rd_use1 = 1'($urandom_range(0, 1));
            s_rd_use2 = 1'($urandom_range(0, 1));
            s_iss_en = 1'($urandom_range(0, 1));
            s_iss_addr = raddr();
            s_wr_en = 1'($urandom_range(0, 1));
            s_wr_addr = raddr();
            s_wr_data = $urandom;
            s_sys_wr_en = ($urandom_range(0, 9) == 0);
            s_sys_wr_addr = raddr();
            s_sys_wr_data = $urandom;
            tick();
        end
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
